uart_loopback_top: RTL and testbench



---
 rtl/uart_loopback_top.sv | 208 ++++++++++++++++++++
 tb/tb_uart_loopback_top.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_top.sv
// UART TX and RX sharing one baud-tick generator, with the TX line looped back into RX.
// Define UART_PARITY_EN for an even-parity bit, which adds the parity_err output.
module uart_loopback_top #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx_done,
  output logic       rx_done,
`ifdef UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic [7:0] data_out
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TW'(DIV - 1));

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || w_tick) r_tick_cnt <= '0;
    else                 r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // ---------------- transmitter ----------------
  state_e        r_tx_state, w_tx_next;
  logic [OW-1:0] r_tx_tick;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_shreg;
  logic          w_tx_bit_end;
  logic          w_tx_line;
`ifdef UART_PARITY_EN
  logic          r_tx_par;
`endif

  assign w_tx_bit_end = w_tick && (r_tx_tick == OW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) r_tx_state <= S_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  // NOTE: defaults are assigned first so no path leaves an output unassigned (no latch).
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_line = 1'b1;
    case (r_tx_state)
      S_IDLE:  if (tx_start) w_tx_next = S_START;
      S_START: begin
        w_tx_line = 1'b0;
        if (w_tx_bit_end) w_tx_next = S_DATA;
      end
      S_DATA: begin
        w_tx_line = r_tx_shreg[0];
        if (w_tx_bit_end && r_tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          w_tx_next = S_PARITY;
`else
          w_tx_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_bit_end) w_tx_next = S_STOP;
      end
`endif
      S_STOP:  if (w_tx_bit_end) w_tx_next = S_IDLE;
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_tick  <= '0;
      r_tx_idx   <= '0;
      r_tx_shreg <= '0;
      tx_done    <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      tx_done <= (r_tx_state == S_STOP) && w_tx_bit_end;
      if (r_tx_state == S_IDLE) begin
        r_tx_tick <= '0;
        r_tx_idx  <= '0;
        if (tx_start) begin
          r_tx_shreg <= data_in;
`ifdef UART_PARITY_EN
          r_tx_par   <= ^data_in;
`endif
        end
      end else if (w_tick) begin
        r_tx_tick <= w_tx_bit_end ? '0 : r_tx_tick + OW'(1);
        if (w_tx_bit_end && r_tx_state == S_DATA) begin
          r_tx_shreg <= r_tx_shreg >> 1;
          r_tx_idx   <= r_tx_idx + 3'd1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]    r_rx_sync;
  state_e        r_rx_state, w_rx_next;
  logic [OW-1:0] r_rx_tick;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shreg;
  logic          w_rx;
  logic          w_rx_mid;
  logic          w_rx_bit_end;
  logic          w_rx_par_ok;
`ifdef UART_PARITY_EN
  logic          r_rx_par;
  assign w_rx_par_ok = (r_rx_par == ^r_rx_shreg);
`else
  assign w_rx_par_ok = 1'b1;
`endif

  assign w_rx         = r_rx_sync[1];
  assign w_rx_mid     = w_tick && (r_rx_tick == OW'(OVERSAMPLE / 2 - 1));
  assign w_rx_bit_end = w_tick && (r_rx_tick == OW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= S_IDLE;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], w_tx_line};
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (!w_rx) w_rx_next = S_START;
      S_START: if (w_rx_mid) w_rx_next = w_rx ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_rx_bit_end && r_rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          w_rx_next = S_PARITY;
`else
          w_rx_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (w_rx_bit_end) w_rx_next = S_STOP;
`endif
      S_STOP:  if (w_rx_bit_end) w_rx_next = S_IDLE;
      default: w_rx_next = S_IDLE;
    endcase
  end

  // Sampling happens mid-bit: START realigns the counter at half a bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_tick  <= '0;
      r_rx_idx   <= '0;
      r_rx_shreg <= '0;
      rx_done    <= 1'b0;
      data_out   <= 8'h00;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (r_rx_state == S_IDLE) begin
        r_rx_tick <= '0;
        r_rx_idx  <= '0;
      end else if (w_tick) begin
        r_rx_tick <= (w_rx_bit_end || (r_rx_state == S_START && w_rx_mid)) ?
                     '0 : r_rx_tick + OW'(1);
        if (w_rx_bit_end && r_rx_state == S_DATA) begin
          r_rx_shreg <= {w_rx, r_rx_shreg[7:1]};
          r_rx_idx   <= r_rx_idx + 3'd1;
        end
`ifdef UART_PARITY_EN
        if (w_rx_bit_end && r_rx_state == S_PARITY) r_rx_par <= w_rx;
        if (w_rx_bit_end && r_rx_state == S_STOP && !w_rx_par_ok) parity_err <= 1'b1;
`endif
        if (w_rx_bit_end && r_rx_state == S_STOP && w_rx && w_rx_par_ok) begin
          rx_done  <= 1'b1;
          data_out <= r_rx_shreg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_loopback_top.sv
// Randomized loopback bench for uart_loopback_top: a byte-level model predicts every received byte.
module tb_uart_loopback_top;

  localparam int DIV = 54;
  localparam int OS  = 16;
`ifdef UART_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int TX_LAT = BITS * OS * DIV;
  localparam int RX_LAT = (BITS * OS - OS / 2) * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_done, rx_done;
  logic [7:0] data_out;
`ifdef UART_PARITY_EN
  logic       parity_err;
`endif

  uart_loopback_top dut (
    .clk       (clk),
    .reset     (reset),
    .tx_start  (tx_start),
    .data_in   (data_in),
    .tx_done   (tx_done),
    .rx_done   (rx_done),
`ifdef UART_PARITY_EN
    .parity_err(parity_err),
`endif
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rx_cnt = 0, tx_cnt = 0, perr_cnt = 0;
  int rx_run = 0, tx_run = 0, rx_wmax = 0, tx_wmax = 0;
  int last_rx_cyc = 0, last_tx_cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      rx_cnt++;
      rx_q.push_back(data_out);
      last_rx_cyc = cyc;
      rx_run++;
      if (rx_run > rx_wmax) rx_wmax = rx_run;
    end else rx_run = 0;
    if (tx_done) begin
      tx_cnt++;
      last_tx_cyc = cyc;
      tx_run++;
      if (tx_run > tx_wmax) tx_wmax = tx_run;
    end else tx_run = 0;
`ifdef UART_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, output int c);
    @(negedge clk);
    tx_start = 1'b1;
    data_in  = b;
    c        = cyc;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // One frame: the byte is expected back on data_out; an optional stray tx_start mid-frame must be ignored.
  task automatic do_frame(input string tag, input logic [7:0] b, input int stray_at,
                          input logic [7:0] stray_b);
    int c, rx0, tx0, rx_lat, tx_lat;
    bit ok;
    rx0 = rx_cnt;
    tx0 = tx_cnt;
    exp_q.push_back(b);
    send(b, c);
    ok = 1'b0;
    for (int i = 0; i < TX_LAT + 400; i++) begin
      @(negedge clk);
      tx_start = (stray_at > 0) && (i == stray_at);
      if (tx_start) data_in = stray_b;
      if (tx_cnt != tx0) begin
        ok = 1'b1;
        break;
      end
    end
    tx_start = 1'b0;
    rx_lat = last_rx_cyc - c - 1;
    tx_lat = last_tx_cyc - c - 1;
    check({tag, "_tx_seen"}, ok, 1);
    check({tag, "_rx_count"}, rx_cnt - rx0, 1);
    check({tag, "_tx_count"}, tx_cnt - tx0, 1);
    check({tag, "_data"}, data_out, b);
    check({tag, "_rx_before_tx"}, last_rx_cyc < last_tx_cyc, 1);
    check({tag, "_rx_latency"},
          (rx_lat >= RX_LAT - (DIV + 3)) && (rx_lat <= RX_LAT + DIV + 3), 1);
    check({tag, "_tx_latency"},
          (tx_lat >= TX_LAT - DIV) && (tx_lat <= TX_LAT + DIV), 1);
  endtask

  initial begin
    int c, rx0, tx0, gap;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_tx_done", tx_done, 0);
    check("reset_rx_done", rx_done, 0);
    check("reset_data_out", data_out, 8'h00);
    check("reset_line", dut.w_tx_line, 1);
    reset = 1'b0;

    do_frame("loop_ce", 8'hCE, 0, 8'h00);
    do_frame("busy_a5", 8'hA5, 3000, 8'h3C);
    rx0 = rx_cnt;
    repeat (600) @(negedge clk);
    check("busy_no_extra", rx_cnt - rx0, 0);

    do_frame("b2b_00", 8'h00, 0, 8'h00);
    do_frame("b2b_ff", 8'hFF, 0, 8'h00);

    rx0 = rx_cnt;
    tx0 = tx_cnt;
    send(8'h55, c);
    repeat (4000) @(negedge clk);
    pulse_reset();
    repeat (5000) @(negedge clk);
    check("abort_rx_count", rx_cnt - rx0, 0);
    check("abort_tx_count", tx_cnt - tx0, 0);
    check("abort_data_out", data_out, 8'h00);
    do_frame("after_abort_81", 8'h81, 0, 8'h00);

    for (int k = 0; k < 3; k++) begin
      gap = $urandom_range(0, 20);
      repeat (gap) @(negedge clk);
      b = 8'($urandom);
      do_frame($sformatf("rand%0d", k), b, int'($urandom_range(200, 7000)), 8'($urandom));
    end

    check("rx_pulse_width", rx_wmax, 1);
    check("tx_pulse_width", tx_wmax, 1);
    check("parity_err_count", perr_cnt, 0);
    check("stream_length", rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check("stream_byte", rx_q.pop_front(), exp_q.pop_front());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
